// File: rtl/ram_pkg.sv
// Shared definitions for the clear-capable simple-dual-port RAM.
//   state_e  : clear engine states (ST_CLEAR fills the array, ST_RUN serves ports)
//   RDW_OLD  : same-address read during write returns the pre-write word
//   RDW_NEW  : same-address read during write returns the newly written bytes
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/ram_clr_fsm.sv
// Clear engine for ram_sdp_clr. It sweeps every address once after reset or
// on request, then hands the ports back to the user.
//   clk, rst_n : clock, asynchronous active-high reset
//   clr_req    : one-cycle clear request, honoured only in ST_RUN
//   ready      : 1 while in ST_RUN (user ports enabled)
//   clr_done   : one-cycle pulse on the cycle after the last clear write
//   clr_we     : clear write strobe for the array
//   clr_addr   : clear write address
module ram_clr_fsm
  import ram_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          ready,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        // Counter wraps to 0 after the last word, ready for the next clear.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign ready    = (state_q == ST_RUN);
  assign clr_we   = (state_q == ST_CLEAR);
  assign clr_addr = cnt_q;
  assign clr_done = done_q;

endmodule

// File: rtl/ram_sdp_clr.sv
// Simple-dual-port synchronous RAM with byte enables, 1- or 2-cycle read
// latency, selectable read-during-write policy and a built-in clear engine.
//   clk, rst_n          : clock, asynchronous active-high reset
//   clr_req             : request a full clear (ignored while clearing)
//   ready, clr_done     : port-enable status and end-of-clear pulse
//   wr_en/addr/be/data  : write port, accepted when wr_en & ready
//   rd_en/addr          : read port, accepted when rd_en & ready
//   rd_valid, rd_data   : read result, RD_LAT cycles after acceptance;
//                         rd_data holds while rd_valid is low
module ram_sdp_clr
  import ram_pkg::*;
#(
  parameter int            DW       = 16,
  parameter int            AW       = 3,
  parameter int            RD_LAT   = 1,
  parameter int            RDW_MODE = 0,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_req,
  output logic            ready,
  output logic            clr_done,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW/8-1:0] wr_be,
  input  logic [DW-1:0]   wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data
);

  localparam int NBE   = DW / 8;
  localparam int DEPTH = 1 << AW;

  if ((DW % 8) != 0 || (RD_LAT != 1 && RD_LAT != 2) ||
      (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW)) begin : g_param_chk
    $error("ram_sdp_clr: DW must be a multiple of 8, RD_LAT 1 or 2, RDW_MODE 0 or 1");
  end

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  ram_clr_fsm #(.AW(AW)) u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .ready    (ready),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic wr_acc, rd_acc;
  assign wr_acc = wr_en & ready;
  assign rd_acc = rd_en & ready;

  // Write-port mux: the clear engine owns the port whenever ready is low,
  // so it never competes with an accepted user write.
  logic                     mem_we;
  logic [AW-1:0]            mem_addr;
  logic [NBE-1:0]           mem_be;
  logic [NBE-1:0][7:0]      mem_wdata;

  always_comb begin
    mem_we    = wr_acc;
    mem_addr  = wr_addr;
    mem_be    = wr_be;
    mem_wdata = wr_data;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_be    = '1;
      mem_wdata = INIT_VAL;
    end
  end

  logic [NBE-1:0][7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NBE; i++) begin
      if (mem_we && mem_be[i]) mem_q[mem_addr][i] <= mem_wdata[i];
    end
  end

  // Array is sampled combinationally before the accepting edge, which
  // naturally yields the old word; write-first mode patches in the
  // enabled bytes of a same-address accepted write.
  logic [NBE-1:0][7:0] rd_old, rd_word, wr_bytes;
  logic                hit;

  assign rd_old   = mem_q[rd_addr];
  assign wr_bytes = wr_data;
  assign hit      = (RDW_MODE == RDW_NEW) && wr_acc && (wr_addr == rd_addr);

  always_comb begin
    rd_word = rd_old;
    for (int i = 0; i < NBE; i++) begin
      if (hit && wr_be[i]) rd_word[i] = wr_bytes[i];
    end
  end

  // Read pipeline: each stage captures only when a valid token arrives so
  // the output holds its last value between reads.
  logic [RD_LAT:1]         vld_pipe_q, vld_pipe_d;
  logic [RD_LAT:1][DW-1:0] dat_q, dat_d;

  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    dat_d         = dat_q;
    vld_pipe_d[1] = rd_acc;
    if (rd_acc) dat_d[1] = rd_word;
    for (int k = 2; k <= RD_LAT; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      if (vld_pipe_q[k-1]) dat_d[k] = dat_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      vld_pipe_q <= '0;
      dat_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dat_q      <= dat_d;
    end
  end

  assign rd_valid = vld_pipe_q[RD_LAT];
  assign rd_data  = dat_q[RD_LAT];

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Directed bench for ram_sdp_clr. Two instances share one stimulus stream:
// dut_a (RD_LAT=1, old-data collisions) and dut_b (RD_LAT=2, write-first).
module tb_ram_sdp_clr;

  logic        clk;
  logic        rst_n;
  logic        clr_req;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [1:0]  wr_be;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [2:0]  rd_addr;

  logic        ready_a, clr_done_a, rd_valid_a;
  logic [15:0] rd_data_a;
  logic        ready_b, clr_done_b, rd_valid_b;
  logic [15:0] rd_data_b;

  int n_pass = 0;
  int n_chk  = 0;

  ram_sdp_clr #(.DW(16), .AW(3), .RD_LAT(1), .RDW_MODE(0), .INIT_VAL(16'hA5A5)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready_a), .clr_done(clr_done_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid_a), .rd_data(rd_data_a)
  );

  ram_sdp_clr #(.DW(16), .AW(3), .RD_LAT(2), .RDW_MODE(1), .INIT_VAL(16'hA5A5)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready_b), .clr_done(clr_done_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid_b), .rd_data(rd_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  // Read with latency check: dut_a answers one cycle after acceptance,
  // dut_b two cycles after. Any write set up by the caller rides the same edge.
  task automatic read_chk(input string tag, input logic [2:0] a,
                          input logic [15:0] ea, input logic [15:0] eb);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    chk({tag, "_a_vld"}, 32'(rd_valid_a), 1);
    chk({tag, "_a_dat"}, 32'(rd_data_a), 32'(ea));
    chk({tag, "_b_early"}, 32'(rd_valid_b), 0);
    tick();
    chk({tag, "_b_vld"}, 32'(rd_valid_b), 1);
    chk({tag, "_b_dat"}, 32'(rd_data_b), 32'(eb));
    chk({tag, "_a_drop"}, 32'(rd_valid_a), 0);
  endtask

  // Expects to be called on the first sample where ready has just gone low.
  task automatic wait_clear(input string tag);
    int   n;
    logic v;
    n = 0; v = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ready_a) break;
      n++;
      v = v | rd_valid_a | rd_valid_b;
      tick();
    end
    chk({tag, "_len"}, 32'(n), 8);
    chk({tag, "_done"}, 32'(clr_done_a), 1);
    chk({tag, "_done_b"}, 32'(clr_done_b), 1);
    chk({tag, "_rdy_b"}, 32'(ready_b), 1);
    chk({tag, "_no_vld"}, 32'(v), 0);
    tick();
    chk({tag, "_done_lo"}, 32'(clr_done_a), 0);
  endtask

  initial begin
    rst_n = 1'b1; clr_req = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    tick(); tick(); tick();

    // Reset state
    chk("rst_ready",  32'(ready_a),    0);
    chk("rst_done",   32'(clr_done_a), 0);
    chk("rst_vld_a",  32'(rd_valid_a), 0);
    chk("rst_vld_b",  32'(rd_valid_b), 0);
    chk("rst_dat_a",  32'(rd_data_a),  0);
    chk("rst_dat_b",  32'(rd_data_b),  0);

    // 1: initial clear, then back-to-back reads of every word
    rst_n = 1'b0;
    wait_clear("init");
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; rd_addr = 3'(i);
      tick();
      chk("b2b_a_vld", 32'(rd_valid_a), 1);
      chk("b2b_a_dat", 32'(rd_data_a), 32'h0000A5A5);
      if (i > 0) begin
        chk("b2b_b_vld", 32'(rd_valid_b), 1);
        chk("b2b_b_dat", 32'(rd_data_b), 32'h0000A5A5);
      end
    end
    rd_en = 1'b0;
    tick();
    chk("b2b_b_last", 32'(rd_data_b), 32'h0000A5A5);
    chk("b2b_a_idle", 32'(rd_valid_a), 0);
    tick();
    chk("hold_a", 32'(rd_data_a), 32'h0000A5A5);
    chk("idle_b", 32'(rd_valid_b), 0);

    // 2: full-word write then read, both latencies
    wr(3'd3, 16'h1234, 2'b11);
    read_chk("wr3", 3'd3, 16'h1234, 16'h1234);

    // 3: upper byte only
    wr(3'd5, 16'h3C00, 2'b10);
    read_chk("be5", 3'd5, 16'h3CA5, 16'h3CA5);

    // wr_be = 0 leaves the word untouched
    wr(3'd5, 16'hFFFF, 2'b00);
    read_chk("be0", 3'd5, 16'h3CA5, 16'h3CA5);

    // 4: same-address collision, low byte only
    wr(3'd2, 16'h1111, 2'b11);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h2222; wr_be = 2'b01;
    read_chk("coll", 3'd2, 16'h1111, 16'h1122);
    read_chk("coll_after", 3'd2, 16'h1122, 16'h1122);

    // different-address write alongside a read has no effect on it
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hBEEF; wr_be = 2'b11;
    read_chk("diff", 3'd3, 16'h1234, 16'h1234);
    read_chk("diff_wr", 3'd4, 16'hBEEF, 16'hBEEF);

    // 5: clr_req with write+read in the same cycle; ports ignored during clear
    clr_req = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h5555; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 3'd1;
    tick();
    clr_req = 1'b0;
    chk("clr_a_vld", 32'(rd_valid_a), 1);
    chk("clr_a_dat", 32'(rd_data_a), 32'h0000A5A5);
    chk("clr_rdy0",  32'(ready_a), 0);
    wr_addr = 3'd3; wr_data = 16'h0000; rd_addr = 3'd3;
    begin
      int n;
      n = 1;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (ready_a) break;
        n++;
        chk("clr_a_none", 32'(rd_valid_a), 0);
        if (i == 0) begin
          chk("clr_b_vld", 32'(rd_valid_b), 1);
          chk("clr_b_dat", 32'(rd_data_b), 32'h00005555);
        end else begin
          chk("clr_b_none", 32'(rd_valid_b), 0);
        end
      end
      chk("clr_len", 32'(n), 8);
      chk("clr_done", 32'(clr_done_a), 1);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
    read_chk("clr_w1", 3'd1, 16'hA5A5, 16'hA5A5);
    read_chk("clr_w3", 3'd3, 16'hA5A5, 16'hA5A5);

    // 6a: reset with a read in flight
    rd_en = 1'b1; rd_addr = 3'd3;
    tick();
    rd_en = 1'b0;
    chk("inflt_a_vld", 32'(rd_valid_a), 1);
    rst_n = 1'b1;
    #1;
    chk("inflt_a_rst", 32'(rd_valid_a), 0);
    chk("inflt_a_dat", 32'(rd_data_a), 0);
    chk("inflt_rdy", 32'(ready_a), 0);
    tick();
    rst_n = 1'b0;
    wait_clear("rst_rd");

    // 6b: reset at the fourth clear cycle restarts the sweep
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick(); tick(); tick();
    chk("mid_rdy0", 32'(ready_a), 0);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    wait_clear("rst_mid");
    read_chk("final", 3'd0, 16'hA5A5, 16'hA5A5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
